jt51_slot_wr_sched: RTL

- Schedules register-file updates into a time-multiplexed, 32-slot recirculating shift ring.
- Host-side write requests are (slot, data) pairs. The block queues them, tracks the current ring slot, and commits each write on the cen cycle where that slot's value leaves the ring.
- On every other cycle the ring recirculates unchanged.
- Sits between the register interface and each per-slot parameter shifter. Emits the slot count and a sync pulse that the operator pipeline shares.

---
 rtl/jt51_slot_wr_sched_pkg.sv | 14 +
 rtl/jt51_slot_wr_sched_if.sv | 26 ++
 rtl/jt51_slot_wr_sched_fifo.sv | 61 ++++++
 rtl/jt51_slot_wr_sched.sv | 88 ++++++++
 4 files changed

// File: rtl/jt51_slot_wr_sched_pkg.sv
// Shared definitions for the JT51 slot write scheduler slice.
package jt51_pkg;

    localparam int JT51_SLOTS  = 32;
    localparam int JT51_SLOT_W = 5;

    typedef logic [JT51_SLOT_W-1:0] slot_t;

    // Next ring slot index, wrapping after the last populated slot.
    function automatic slot_t next_slot(input slot_t s, input slot_t last);
        return (s == last) ? '0 : s + slot_t'(1);
    endfunction

endpackage

// File: rtl/jt51_slot_wr_sched_if.sv
// Host write request channel: (slot, data) with valid/ready handshake.
interface jt51_slot_wr_sched_if #(
    parameter int width = 5
);
    import jt51_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    slot_t            wr_slot;
    logic [width-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_slot,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_slot,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/jt51_slot_wr_sched_fifo.sv
// Pending-write FIFO: in-order (slot, data) storage with async reset.
// The caller never pushes when full nor pops when empty.
module jt51_wr_fifo
    import jt51_pkg::*;
#(
    parameter int width = 5,
    parameter int depth = 2
) (
    input  logic                     rst,
    input  logic                     clk,
    input  logic                     push,
    input  logic                     pop,
    input  slot_t                    din_slot,
    input  logic [width-1:0]         din_data,
    output logic [$clog2(depth):0]   count,
    output slot_t                    head_slot,
    output logic [width-1:0]         head_data
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    logic [width-1:0] data_mem [depth];
    slot_t            slot_mem [depth];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= din_data;
            slot_mem[wr_ptr] <= din_slot;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry is the only one the scheduler may commit.
    always_comb begin
        head_slot = slot_mem[rd_ptr];
        head_data = data_mem[rd_ptr];
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop |-> (count != '0));

endmodule

// File: rtl/jt51_slot_wr_sched.sv
// Slot write scheduler: queues host writes and splices each one into the
// recirculating 32-slot ring on the cen cycle where its slot is at ring_drop.
module jt51_slot_wr_sched
    import jt51_pkg::*;
#(
    parameter int width  = 5,
    parameter int stages = JT51_SLOTS,
    parameter int depth  = 2
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 cen,
    jt51_slot_wr_sched_if.slave  wr,
    input  logic [width-1:0]     ring_drop,
    output logic [width-1:0]     ring_din,
    output slot_t                cur_slot,
    output logic                 sync,
    output logic                 wr_done,
    output logic                 busy
);

    localparam int CW = $clog2(depth) + 1;
    localparam slot_t                  LAST    = slot_t'(stages - 1);
    localparam logic [JT51_SLOT_W:0]   LIMIT   = (JT51_SLOT_W + 1)'(stages);
    localparam logic [CW-1:0]          DEPTH_C = CW'(depth);

    logic [CW-1:0]    count;
    slot_t            head_slot;
    logic [width-1:0] head_data;
    logic             rdy_en;
    logic             accept;
    logic             slot_ok;
    logic             push;
    logic             hit;

    jt51_wr_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo (
        .rst       (rst),
        .clk       (clk),
        .push      (push),
        .pop       (hit),
        .din_slot  (wr.wr_slot),
        .din_data  (wr.wr_data),
        .count     (count),
        .head_slot (head_slot),
        .head_data (head_data)
    );

    // Handshake: ready only from registered count, so a full FIFO refuses
    // a push even when the head pops in the same cycle.
    always_comb begin
        wr.wr_ready = rdy_en & (count < DEPTH_C);
        accept      = wr.wr_valid & wr.wr_ready;
        slot_ok     = {1'b0, wr.wr_slot} < LIMIT;
        push        = accept & slot_ok;
    end

    // Commit mux: only the head may land, and only on an advancing cycle.
    always_comb begin
        busy     = (count != '0);
        hit      = busy & cen & (head_slot == cur_slot);
        ring_din = hit ? head_data : ring_drop;
        sync     = (cur_slot == '0);
    end

    // Slot counter tracks which slot's value is at the ring output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_slot <= '0;
        end else if (cen) begin
            cur_slot <= next_slot(cur_slot, LAST);
        end
    end

    // Ready enable comes up on the first edge after reset; wr_done echoes a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en  <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            wr_done <= hit;
        end
    end

endmodule
